// File: rtl/decoder_pkg.sv
// Shared helpers for the one-hot address decoder.
package decoder_pkg;

    // True when n is a power of two, i.e. every index of a $clog2(n)-bit address is in range.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational binary-to-one-hot decode with enable and out-of-range detection.
module decoder_core
    import decoder_pkg::*;
#(
    parameter  int unsigned NUM_WIRE = 5,
    localparam int unsigned AW       = $clog2(NUM_WIRE)
) (
    input  logic [AW-1:0]       a_i,
    input  logic                a_valid_i,
    output logic [NUM_WIRE-1:0] d_o,
    output logic                oor_o
);

    always_comb begin
        d_o = '0;
        for (int unsigned k = 0; k < NUM_WIRE; k++) begin
            d_o[k] = a_valid_i && (a_i == AW'(k));
        end
    end

    // Out-of-range indices exist only when NUM_WIRE leaves unused codes in the address space.
    if (is_pow2(NUM_WIRE)) begin : g_pow2
        assign oor_o = 1'b0;
    end else begin : g_npow2
        assign oor_o = a_valid_i && (a_i > AW'(NUM_WIRE - 1));
    end

endmodule

// File: rtl/decoder.sv
// One-hot address decoder: combinational result plus a registered copy for clocked consumers.
module decoder
    import decoder_pkg::*;
#(
    parameter  int unsigned NUM_WIRE = 5,
    localparam int unsigned AW       = $clog2(NUM_WIRE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [AW-1:0]       a_i,
    input  logic                a_valid_i,
    output logic [NUM_WIRE-1:0] d_o,
    output logic [NUM_WIRE-1:0] d_q_o,
    output logic                oor_o
);

    logic [NUM_WIRE-1:0] dec;
    logic [NUM_WIRE-1:0] dec_q;

    decoder_core #(
        .NUM_WIRE (NUM_WIRE)
    ) u_core (
        .a_i       (a_i),
        .a_valid_i (a_valid_i),
        .d_o       (dec),
        .oor_o     (oor_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec;
        end
    end

    assign d_o   = dec;
    assign d_q_o = dec_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder at NUM_WIRE=5 and NUM_WIRE=8.
module tb_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] a5, a8;
    logic       v5, v8;
    logic [4:0] d5, dq5;
    logic [7:0] d8, dq8;
    logic       o5, o8;

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0] sb5[$];
    logic [7:0] sb8[$];

    always #5 clk = ~clk;

    decoder #(
        .NUM_WIRE (5)
    ) u_dut5 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .a_i       (a5),
        .a_valid_i (v5),
        .d_o       (d5),
        .d_q_o     (dq5),
        .oor_o     (o5)
    );

    decoder #(
        .NUM_WIRE (8)
    ) u_dut8 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .a_i       (a8),
        .a_valid_i (v8),
        .d_o       (d8),
        .d_q_o     (dq8),
        .oor_o     (o8)
    );

    function automatic logic [4:0] ref5(input logic [2:0] a, input logic v);
        if (a >= 3'd5) return 5'b0;
        return 5'(v) << a;
    endfunction

    function automatic logic [7:0] ref8(input logic [2:0] a, input logic v);
        return 8'(v) << a;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a5 = 3'd0; v5 = 1'b0; a8 = 3'd0; v8 = 1'b0;
        #2;
        vectors++;
        if (dq5 !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_dq5: got %b want %b", dq5, 5'b0);
        end
        vectors++;
        if (dq8 !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_dq8: got %b want %b", dq8, 8'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_in_range();
        logic [4:0] exp_d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a5 = 3'(i); v5 = 1'b1;
            exp_d = 5'b1 << i;
            #1;
            vectors++;
            if (d5 !== exp_d || o5 !== 1'b0) begin
                miscompares++;
                $display("FAIL in_range a=%0d: got d=%b oor=%b want d=%b oor=0", i, d5, o5, exp_d);
            end
        end
    endtask

    task automatic test_disable();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a5 = 3'(i); v5 = 1'b0;
            #1;
            vectors++;
            if (d5 !== 5'b0 || o5 !== 1'b0) begin
                miscompares++;
                $display("FAIL disable a=%0d: got d=%b oor=%b want d=00000 oor=0", i, d5, o5);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            a5 = 3'(i); v5 = 1'b1;
            #1;
            vectors++;
            if (d5 !== 5'b0 || o5 !== 1'b1) begin
                miscompares++;
                $display("FAIL out_of_range a=%0d: got d=%b oor=%b want d=00000 oor=1", i, d5, o5);
            end
        end
    endtask

    task automatic test_register();
        logic [4:0] exp_q;
        sb5.delete();
        @(negedge clk);
        a5 = 3'd3; v5 = 1'b1;
        sb5.push_back(5'b01000);
        for (int step = 0; step < 2; step++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (sb5.size() == 0) begin
                miscompares++;
                $display("FAIL register_sb step=%0d: got empty scoreboard want entry", step);
            end else begin
                exp_q = sb5.pop_front();
                if (dq5 !== exp_q) begin
                    miscompares++;
                    $display("FAIL register step=%0d: got %b want %b", step, dq5, exp_q);
                end
            end
            if (step == 0) begin
                @(negedge clk);
                v5 = 1'b0;
                sb5.push_back(5'b00000);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a5 = 3'd2; v5 = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (dq5 !== 5'b00100) begin
            miscompares++;
            $display("FAIL async_pre: got %b want %b", dq5, 5'b00100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dq5 !== 5'b0 || d5 !== 5'b00100) begin
            miscompares++;
            $display("FAIL async_clear: got dq=%b d=%b want dq=00000 d=00100", dq5, d5);
        end
        a5 = 3'd0;
        #1;
        vectors++;
        if (d5 !== 5'b00001) begin
            miscompares++;
            $display("FAIL async_track: got %b want %b", d5, 5'b00001);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dq5 !== 5'b0) begin
            miscompares++;
            $display("FAIL async_hold: got %b want %b", dq5, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_soak();
        logic [4:0] exp5;
        logic [7:0] exp8;
        sb5.delete();
        sb8.delete();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a5 = 3'($urandom_range(0, 7)); v5 = 1'($urandom_range(0, 1));
            a8 = 3'($urandom_range(0, 7)); v8 = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (d5 !== ref5(a5, v5) || o5 !== (v5 && a5 >= 3'd5)) begin
                miscompares++;
                $display("FAIL soak5 i=%0d a=%0d v=%b: got d=%b oor=%b want d=%b oor=%b",
                         i, a5, v5, d5, o5, ref5(a5, v5), v5 && a5 >= 3'd5);
            end
            vectors++;
            if (d8 !== ref8(a8, v8) || o8 !== 1'b0) begin
                miscompares++;
                $display("FAIL soak8 i=%0d a=%0d v=%b: got d=%b oor=%b want d=%b oor=0",
                         i, a8, v8, d8, o8, ref8(a8, v8));
            end
            sb5.push_back(ref5(a5, v5));
            sb8.push_back(ref8(a8, v8));
            @(posedge clk);
            #1;
            vectors++;
            if (sb5.size() == 0 || sb8.size() == 0) begin
                miscompares++;
                $display("FAIL soak_sb i=%0d: got empty scoreboard want entry", i);
            end else begin
                exp5 = sb5.pop_front();
                exp8 = sb8.pop_front();
                if (dq5 !== exp5 || dq8 !== exp8) begin
                    miscompares++;
                    $display("FAIL soak_q i=%0d: got dq5=%b dq8=%b want dq5=%b dq8=%b",
                             i, dq5, dq8, exp5, exp8);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_range();
        test_disable();
        test_out_of_range();
        test_register();
        test_async_reset();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
